// File: rtl/calc_seq_if.sv
// Operand/op request and result bus between the operand registers and calc_seq_core.
interface calc_seq_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 4
) ();

  logic                  start;
  logic [1:0]            op;
  logic [W-1:0]          a;
  logic [W-1:0]          b;
  logic                  busy;
  logic                  done;
  logic [2*W-1:0]        result;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     dp;
  logic                  neg;
  logic                  div_err;
  logic                  ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, bcd, dp, neg, div_err, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, bcd, dp, neg, div_err, ovf
  );

endinterface

// File: rtl/calc_seq_core.sv
// Sequential calculator core: add/sub/shift-add mul/restoring div, then
// double-dabble to BCD with decimal-point, sign, overflow and div-by-zero flags.
module calc_seq_core #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned FRAC   = 1
) (
  input  logic      clk16M,
  input  logic      rst,
  calc_seq_if.slave bus
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W2) + 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [W2-1:0]     FRAC_SCALE = W2'(pow10(FRAC));
  localparam logic [63:0]       OVF_LIMIT  = pow10(DIGITS);
  localparam logic [BW-1:0]     NINES      = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] DP_DIV     = DIGITS'(1) << FRAC;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;      // divisor, or multiplier shifted right during mul
  logic [W2-1:0]   res_q;    // mul accumulator / div quotient / final magnitude
  logic [W2-1:0]   sh_q;     // mul multiplicand, div dividend, then binary fed to BCD
  logic [W-1:0]    rem_q;
  logic [BW-1:0]   bcd_q;
  logic            neg_q;

  logic [W2-1:0]   add_c;
  logic [W2-1:0]   sub_c;
  logic [W2-1:0]   mul_acc_c;
  logic [W:0]      div_sh_c;
  logic            div_ge_c;
  logic [W-1:0]    div_rem_c;
  logic [W2-1:0]   quo_c;
  logic [BW-1:0]   dd_adj_c;
  logic [BW-1:0]   dd_next_c;
  logic            ovf_c;

  // Datapath step for each op plus one double-dabble step (adjust, then shift)
  always_comb begin
    add_c     = W2'(a_q) + W2'(b_q);
    sub_c     = (a_q >= b_q) ? W2'(a_q - b_q) : W2'(b_q - a_q);
    mul_acc_c = res_q + (b_q[0] ? sh_q : '0);
    div_sh_c  = {rem_q, sh_q[W2-1]};
    div_ge_c  = (div_sh_c >= {1'b0, b_q});
    div_rem_c = div_ge_c ? W'(div_sh_c - {1'b0, b_q}) : W'(div_sh_c);
    quo_c     = {res_q[W2-2:0], div_ge_c};
    dd_adj_c  = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) dd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_next_c = BW'({dd_adj_c, sh_q[W2-1]});
    ovf_c     = (64'(res_q) >= OVF_LIMIT);
  end

  // Sequencer: IDLE -> CALC -> CONV -> DONE, outputs loaded on entry to DONE
  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sh_q        <= '0;
      rem_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.bcd     <= '0;
      bus.dp      <= '0;
      bus.neg     <= 1'b0;
      bus.div_err <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            cnt      <= '0;
            res_q    <= '0;
            rem_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            bus.busy <= 1'b1;
            sh_q     <= (bus.op == OP_DIV) ? W2'(bus.a) * FRAC_SCALE : W2'(bus.a);
            if (bus.op == OP_DIV && bus.b == '0) begin
              // Divide by zero skips straight to DONE with only the error flag set
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.result  <= '0;
              bus.bcd     <= '0;
              bus.dp      <= '0;
              bus.neg     <= 1'b0;
              bus.div_err <= 1'b1;
              bus.ovf     <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          case (op_q)
            OP_ADD: begin
              res_q <= add_c;
              sh_q  <= add_c;
              cnt   <= '0;
              state <= CONV;
            end
            OP_SUB: begin
              res_q <= sub_c;
              sh_q  <= sub_c;
              neg_q <= (a_q < b_q);
              cnt   <= '0;
              state <= CONV;
            end
            OP_MUL: begin
              res_q <= mul_acc_c;
              sh_q  <= sh_q << 1;
              b_q   <= b_q >> 1;
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(W - 1)) begin
                sh_q  <= mul_acc_c;
                cnt   <= '0;
                state <= CONV;
              end
            end
            default: begin
              rem_q <= div_rem_c;
              res_q <= quo_c;
              sh_q  <= sh_q << 1;
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(W2 - 1)) begin
                sh_q  <= quo_c;
                cnt   <= '0;
                state <= CONV;
              end
            end
          endcase
        end

        CONV: begin
          bcd_q <= dd_next_c;
          sh_q  <= sh_q << 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W2 - 1)) begin
            cnt         <= '0;
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.result  <= res_q;
            bus.bcd     <= ovf_c ? NINES : dd_next_c;
            bus.dp      <= (op_q == OP_DIV) ? DP_DIV : '0;
            bus.neg     <= neg_q;
            bus.div_err <= 1'b0;
            bus.ovf     <= ovf_c;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: directed table, random ops against an arithmetic model,
// and hand-written sequences for restart, held start and mid-operation reset.
module tb_calc_seq_core;

  localparam int unsigned W      = 8;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned FRAC   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  calc_seq_if #(.W(W), .DIGITS(DIGITS)) bus ();

  calc_seq_core #(.W(W), .DIGITS(DIGITS), .FRAC(FRAC)) dut (
    .clk16M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        neg;
    logic        err;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] res;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        neg;
    logic        err;
    logic        ovf;
    int          lat;
    logic        busy_ok;
    logic        tail_ok;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        neg;
    logic        err;
    logic        ovf;
    int          lat;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // Reference: plain decimal arithmetic on the operands
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int unsigned ai, bi, r, p;
    ai = a;
    bi = b;
    r = 0;
    e.dp = 4'd0; e.neg = 1'b0; e.err = 1'b0; e.ovf = 1'b0; e.bcd = 16'd0;
    case (op)
      2'd0: begin r = ai + bi; e.lat = 1 + 2*W + 1; end
      2'd1: begin r = (ai >= bi) ? ai - bi : bi - ai; e.neg = (ai < bi); e.lat = 1 + 2*W + 1; end
      2'd2: begin r = ai * bi; e.lat = W + 2*W + 1; end
      default: begin
        if (bi == 0) begin
          r = 0; e.err = 1'b1; e.lat = 1;
        end else begin
          r = (ai * (10 ** FRAC)) / bi;
          e.dp = 4'(1 << FRAC);
          e.lat = 2*W + 2*W + 1;
        end
      end
    endcase
    e.res = 16'(r);
    e.ovf = (r >= 10 ** DIGITS);
    if (e.ovf) e.bcd = 16'h9999;
    else begin
      p = 1;
      for (int i = 0; i < 4; i++) begin
        e.bcd[4*i +: 4] = 4'((r / p) % 10);
        p = p * 10;
      end
    end
    return e;
  endfunction

  // Issue one request and collect outputs at the done pulse (cycle count from the start edge)
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output obs_t g);
    g.lat = -1; g.busy_ok = 1'b1; g.tail_ok = 1'b0;
    g.res = '0; g.bcd = '0; g.dp = '0; g.neg = 1'b0; g.err = 1'b0; g.ovf = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 2'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      if (!bus.busy) g.busy_ok = 1'b0;
      if (bus.done) begin
        g.lat = k; g.res = bus.result; g.bcd = bus.bcd; g.dp = bus.dp;
        g.neg = bus.neg; g.err = bus.div_err; g.ovf = bus.ovf;
        break;
      end
    end
    if (g.lat > 0) begin
      @(negedge clk);
      g.tail_ok = !bus.done && !bus.busy;
    end
  endtask

  task automatic compare(input string tag, input obs_t g, input exp_t e);
    chk({tag, " latency"}, 32'(g.lat), 32'(e.lat));
    chk({tag, " result"},  32'(g.res), 32'(e.res));
    chk({tag, " bcd"},     32'(g.bcd), 32'(e.bcd));
    chk({tag, " dp"},      32'(g.dp),  32'(e.dp));
    chk({tag, " neg"},     32'(g.neg), 32'(e.neg));
    chk({tag, " div_err"}, 32'(g.err), 32'(e.err));
    chk({tag, " ovf"},     32'(g.ovf), 32'(e.ovf));
    chk({tag, " busy_held"}, 32'(g.busy_ok), 32'd1);
    chk({tag, " single_done"}, 32'(g.tail_ok), 32'd1);
  endtask

  vec_t tbl [16];

  initial begin
    obs_t g;
    exp_t e;
    int   ndone, first, second;
    logic [15:0] r;

    tbl = '{
      '{2'd0, 8'd200, 8'd100, 16'd300,   16'h0300, 4'b0000, 1'b0, 1'b0, 1'b0, 18},
      '{2'd1, 8'd5,   8'd9,   16'd4,     16'h0004, 4'b0000, 1'b1, 1'b0, 1'b0, 18},
      '{2'd1, 8'd9,   8'd5,   16'd4,     16'h0004, 4'b0000, 1'b0, 1'b0, 1'b0, 18},
      '{2'd2, 8'd255, 8'd255, 16'd65025, 16'h9999, 4'b0000, 1'b0, 1'b0, 1'b1, 25},
      '{2'd3, 8'd7,   8'd2,   16'd35,    16'h0035, 4'b0010, 1'b0, 1'b0, 1'b0, 33},
      '{2'd3, 8'd7,   8'd0,   16'd0,     16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1},
      '{2'd0, 8'd0,   8'd0,   16'd0,     16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 18},
      '{2'd2, 8'd12,  8'd34,  16'd408,   16'h0408, 4'b0000, 1'b0, 1'b0, 1'b0, 25},
      '{2'd3, 8'd255, 8'd1,   16'd2550,  16'h2550, 4'b0010, 1'b0, 1'b0, 1'b0, 33},
      '{2'd3, 8'd1,   8'd3,   16'd3,     16'h0003, 4'b0010, 1'b0, 1'b0, 1'b0, 33},
      '{2'd2, 8'd100, 8'd100, 16'd10000, 16'h9999, 4'b0000, 1'b0, 1'b0, 1'b1, 25},
      '{2'd2, 8'd99,  8'd101, 16'd9999,  16'h9999, 4'b0000, 1'b0, 1'b0, 1'b0, 25},
      '{2'd1, 8'd0,   8'd255, 16'd255,   16'h0255, 4'b0000, 1'b1, 1'b0, 1'b0, 18},
      '{2'd0, 8'd255, 8'd255, 16'd510,   16'h0510, 4'b0000, 1'b0, 1'b0, 1'b0, 18},
      '{2'd3, 8'd255, 8'd255, 16'd10,    16'h0010, 4'b0010, 1'b0, 1'b0, 1'b0, 33},
      '{2'd3, 8'd0,   8'd5,   16'd0,     16'h0000, 4'b0010, 1'b0, 1'b0, 1'b0, 33}
    };

    bus.start = 1'b0; bus.op = 2'd0; bus.a = 8'd0; bus.b = 8'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset busy",    32'(bus.busy),    32'd0);
    chk("reset done",    32'(bus.done),    32'd0);
    chk("reset result",  32'(bus.result),  32'd0);
    chk("reset bcd",     32'(bus.bcd),     32'd0);
    chk("reset dp",      32'(bus.dp),      32'd0);
    chk("reset flags",   32'({bus.neg, bus.div_err, bus.ovf}), 32'd0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      e.res = tbl[i].res; e.bcd = tbl[i].bcd; e.dp = tbl[i].dp; e.neg = tbl[i].neg;
      e.err = tbl[i].err; e.ovf = tbl[i].ovf; e.lat = tbl[i].lat;
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, g);
      compare($sformatf("vec%0d op%0d a=%0d b=%0d", i, tbl[i].op, tbl[i].a, tbl[i].b), g, e);
    end

    // Random operations against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_op(op, a, b, g);
      compare($sformatf("rnd%0d op%0d a=%0d b=%0d", n, op, a, b), g, model(op, a, b));
    end

    // Start pulsed again during CALC and CONV with other operands: ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 8'd3; bus.b = 8'd4;
    @(posedge clk);
    ndone = 0; first = -1; r = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = (k == 3 || k == 20);
      if (k == 3) begin bus.op = 2'd0; bus.a = 8'd50; bus.b = 8'd50; end
      if (bus.done) begin
        ndone++;
        if (first < 0) begin first = k; r = bus.result; end
      end
    end
    chk("restart done_count", 32'(ndone), 32'd1);
    chk("restart latency",    32'(first), 32'd25);
    chk("restart result",     32'(r),     32'd12);

    // Start held high re-triggers only after DONE returns to IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 8'd1; bus.b = 8'd2;
    @(posedge clk);
    ndone = 0; first = -1; second = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) first = k;
        if (ndone == 2) begin second = k; bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    chk("held first_done",  32'(first),      32'd18);
    chk("held second_done", 32'(second),     32'd37);
    chk("held done_count",  32'(ndone),      32'd2);
    chk("held result",      32'(bus.result), 32'd3);

    // Reset during CONV of a multiply aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 8'd255; bus.b = 8'd255;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("abort busy",   32'(bus.busy),   32'd0);
    chk("abort done",   32'(bus.done),   32'd0);
    chk("abort result", 32'(bus.result), 32'd0);
    chk("abort bcd",    32'(bus.bcd),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) first++;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    chk("abort idle",    32'(first), 32'd0);
    do_op(2'd0, 8'd200, 8'd100, g);
    compare("after_abort add 200,100", g, model(2'd0, 8'd200, 8'd100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the bench always ends on its own
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
